// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small power-of-two input FIFO.
// Frames are start(0), DATA_BITS data bits LSB first, an optional parity bit,
// then STOP_BITS stop bits(1). Each bit lasts div_q clocks. div_q is latched
// from divisor when a frame starts. Queued words go out back to back with no
// idle cycle between frames.
// Ports:
//   clk, reset   - clock; synchronous active-high reset
//   divisor      - clocks per bit (0 is treated as 1)
//   data, valid  - producer word and offer; accepted when valid && ready
//   ready        - FIFO not full
//   uart_tx      - serial line, idle high (registered)
//   busy         - frame in progress or FIFO non-empty
//   fifo_count   - occupied FIFO entries
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIV_WIDTH-1:0]               divisor,
    input  logic [DATA_BITS-1:0]               data,
    input  logic                               valid,
    output logic                               ready,
    output logic                               uart_tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Parity bit for a data word: even = XOR of bits, odd = its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        parity_bit = (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    state_t                 state_r, state_s;
    logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_r;
    logic [DIV_WIDTH-1:0]   div_q_r;
    logic [DIV_WIDTH-1:0]   cyc_cnt_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic                   tx_r, tx_s;
    logic                   push_s, pop_s, shift_en_s;
    logic                   bit_end_s, last_data_s, last_stop_s, ready_s;

    // ready is taken from the count only, so a full FIFO refuses a push even
    // when the same edge pops an entry.
    assign ready_s     = (count_r != CNT_W'(FIFO_DEPTH));
    assign push_s      = valid && ready_s;
    // div_q_r is never 0, so div_q_r - 1 cannot wrap.
    assign bit_end_s   = (cyc_cnt_r == (div_q_r - DIV_WIDTH'(1)));
    assign last_data_s = (bit_cnt_r == BIT_W'(DATA_BITS - 1));
    assign last_stop_s = (bit_cnt_r == BIT_W'(STOP_BITS - 1));

    assign ready      = ready_s;
    assign uart_tx    = tx_r;
    assign busy       = (state_r != S_IDLE) || (count_r != CNT_W'(0));
    assign fifo_count = count_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; pop_s marks the only two transitions that dequeue.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    state_s = S_START;
                    pop_s   = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_s = S_DATA;
                end else begin
                    state_s = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s && last_data_s) begin
                    state_s = (PARITY != 0) ? S_PAR : S_STOP;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_PAR: begin
                if (bit_end_s) begin
                    state_s = S_STOP;
                end else begin
                    state_s = S_PAR;
                end
            end
            S_STOP: begin
                if (bit_end_s && last_stop_s) begin
                    if (count_r != CNT_W'(0)) begin
                        state_s = S_START;
                        pop_s   = 1'b1;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_STOP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Next line level; a data bit is driven from shift_r[0] and then shifted out.
    always_comb begin
        tx_s       = tx_r;
        shift_en_s = 1'b0;
        if (pop_s) begin
            tx_s = 1'b0;
        end else if (state_r == S_IDLE) begin
            tx_s = 1'b1;
        end else if (bit_end_s) begin
            case (state_r)
                S_START: begin
                    tx_s       = shift_r[0];
                    shift_en_s = 1'b1;
                end
                S_DATA: begin
                    if (last_data_s) begin
                        tx_s = (PARITY != 0) ? par_r : 1'b1;
                    end else begin
                        tx_s       = shift_r[0];
                        shift_en_s = 1'b1;
                    end
                end
                default: begin
                    tx_s = 1'b1;
                end
            endcase
        end else begin
            tx_s = tx_r;
        end
    end

    // Registered serial output; a reset mid-frame returns the line high at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_r <= 1'b1;
        end else begin
            tx_r <= tx_s;
        end
    end

    // Cycle and bit counters; both restart at each bit or state boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_r <= DIV_WIDTH'(0);
            bit_cnt_r <= BIT_W'(0);
        end else if (pop_s) begin
            cyc_cnt_r <= DIV_WIDTH'(0);
            bit_cnt_r <= BIT_W'(0);
        end else if ((state_r != S_IDLE) && bit_end_s) begin
            cyc_cnt_r <= DIV_WIDTH'(0);
            bit_cnt_r <= (state_s != state_r) ? BIT_W'(0) : (bit_cnt_r + BIT_W'(1));
        end else if (state_r != S_IDLE) begin
            cyc_cnt_r <= cyc_cnt_r + DIV_WIDTH'(1);
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    // Frame datapath: load the head word, its parity and the bit period on a pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= '0;
            par_r   <= 1'b0;
            div_q_r <= DIV_WIDTH'(1);
        end else if (pop_s) begin
            shift_r <= mem_r[rd_ptr_r];
            par_r   <= parity_bit(mem_r[rd_ptr_r]);
            div_q_r <= (divisor == DIV_WIDTH'(0)) ? DIV_WIDTH'(1) : divisor;
        end else if (shift_en_s) begin
            shift_r <= shift_r >> 1;
        end else begin
            shift_r <= shift_r;
        end
    end

    // FIFO storage; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    // FIFO pointers (wrap naturally at the power-of-two depth) and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Three instances cover 8N1, 7E1 and 7O2 frames.
// Each accepted word is queued with its expected bit period. A per-instance
// monitor expands the head entry into the expected line levels and compares
// uart_tx on every cycle of the frame. It also tracks busy, ready and
// fifo_count against a model of the FIFO occupancy.
module tb_uart_tx_fifo;
    typedef struct {
        logic [8:0] word;
        int         dv;
        bit         b2b;
    } exp_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   done_flags [3];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DB = (g == 0) ? 8 : 7;
        localparam int PM = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int SB = (g == 2) ? 2 : 1;
        localparam int FD = 4;

        logic          rst;
        logic [31:0]   divisor;
        logic [DB-1:0] data;
        logic          valid;
        logic          ready;
        logic          tx;
        logic          busy;
        logic [2:0]    fifo_count;
        exp_t          sb_q [$];
        int            model_count = 0;
        bit            active = 1'b0;

        uart_tx_fifo #(
            .DATA_BITS (DB),
            .PARITY    (PM),
            .STOP_BITS (SB),
            .FIFO_DEPTH(FD),
            .DIV_WIDTH (32)
        ) dut (
            .clk       (clk),
            .reset     (rst),
            .divisor   (divisor),
            .data      (data),
            .valid     (valid),
            .ready     (ready),
            .uart_tx   (tx),
            .busy      (busy),
            .fifo_count(fifo_count)
        );

        function automatic string tg(input string s);
            return $sformatf("c%0d_%s", g, s);
        endfunction

        // Offer a word until accepted (bounded); the model decides acceptance.
        task automatic send(input logic [8:0] w, input int dv, input bit b2b, input int budget);
            bit acc;
            acc = 1'b0;
            for (int t = 0; t < budget && !acc; t++) begin
                @(negedge clk);
                #1;
                data  = w[DB-1:0];
                valid = 1'b1;
                acc   = (model_count != FD);
                chk(tg("ready_offer"), 32'(ready), 32'(acc));
                @(posedge clk);
                #1;
                valid = 1'b0;
                if (acc) begin
                    sb_q.push_back('{w, dv, b2b});
                    model_count++;
                end
            end
            chk(tg("accepted"), 32'(acc), 32'd1);
        endtask

        task automatic wait_idle(input int budget);
            bit idle;
            idle = 1'b0;
            for (int t = 0; t < budget && !idle; t++) begin
                @(negedge clk);
                #1;
                idle = !active && (model_count == 0);
            end
            chk(tg("idle_reached"), 32'(idle), 32'd1);
        endtask

        task automatic apply_reset(input int n);
            @(negedge clk);
            #1;
            rst   = 1'b1;
            valid = 1'b0;
            repeat (n) @(posedge clk);
            #1;
            chk(tg("rst_tx"), 32'(tx), 32'd1);
            chk(tg("rst_count"), 32'(fifo_count), 32'd0);
            chk(tg("rst_ready"), 32'(ready), 32'd1);
            chk(tg("rst_busy"), 32'(busy), 32'd0);
            @(negedge clk);
            #1;
            rst = 1'b0;
        endtask

        // Line monitor and occupancy model, sampled on the falling edge.
        initial begin : monitor
            exp_t cur;
            logic bits [16];
            int   nbits;
            int   bit_idx;
            int   cyc;
            int   gap;
            logic par;
            nbits   = 0;
            bit_idx = 0;
            cyc     = 0;
            gap     = 1000;
            cur     = '{9'd0, 1, 1'b0};
            forever begin
                @(negedge clk);
                if (rst === 1'b1) begin
                    active = 1'b0;
                    sb_q.delete();
                    model_count = 0;
                    gap = 1000;
                end else begin
                    if (!active) begin
                        if (tx === 1'b0) begin
                            chk(tg("start_expected"), 32'(sb_q.size() != 0), 32'd1);
                            if (sb_q.size() != 0) begin
                                cur = sb_q.pop_front();
                                model_count--;
                                if (cur.b2b) begin
                                    chk(tg("b2b_gap"), 32'(gap), 32'd0);
                                end
                                bits[0] = 1'b0;
                                par = 1'b0;
                                for (int i = 0; i < DB; i++) begin
                                    bits[1 + i] = cur.word[i];
                                    par = par ^ cur.word[i];
                                end
                                nbits = 1 + DB;
                                if (PM != 0) begin
                                    bits[nbits] = (PM == 2) ? par : ~par;
                                    nbits++;
                                end
                                for (int i = 0; i < SB; i++) begin
                                    bits[nbits] = 1'b1;
                                    nbits++;
                                end
                                active  = 1'b1;
                                bit_idx = 0;
                                cyc     = 0;
                            end
                        end else begin
                            gap++;
                        end
                    end
                    chk(tg("busy"), 32'(busy), 32'(active || (model_count != 0)));
                    chk(tg("fifo_count"), 32'(fifo_count), 32'(model_count));
                    chk(tg("ready"), 32'(ready), 32'(model_count != FD));
                    if (active) begin
                        chk(tg("tx_bit"), 32'(tx), 32'(bits[bit_idx]));
                        cyc++;
                        if (cyc >= cur.dv) begin
                            cyc = 0;
                            bit_idx++;
                            if (bit_idx >= nbits) begin
                                active = 1'b0;
                                gap    = 0;
                            end
                        end
                    end else begin
                        chk(tg("tx_idle"), 32'(tx), 32'd1);
                    end
                end
            end
        end

        if (g == 0) begin : g_stim
            initial begin
                rst = 1'b1; valid = 1'b0; data = '0; divisor = 32'd4;
                apply_reset(3);
                // 0x55 at 4 clocks per bit
                send(9'h055, 4, 1'b0, 4);
                wait_idle(200);
                // Fill: one in flight plus four queued, sixth waits for a pop
                divisor = 32'd8;
                send(9'h011, 8, 1'b0, 4);
                send(9'h022, 8, 1'b1, 4);
                send(9'h033, 8, 1'b1, 4);
                send(9'h044, 8, 1'b1, 4);
                send(9'h0AA, 8, 1'b1, 4);
                send(9'h0F0, 8, 1'b1, 200);
                wait_idle(1000);
                // Reset during data bit 3 with a second word queued
                divisor = 32'd4;
                send(9'h03C, 4, 1'b0, 4);
                send(9'h011, 4, 1'b1, 4);
                repeat (17) @(posedge clk);
                apply_reset(1);
                send(9'h0A5, 4, 1'b0, 4);
                wait_idle(200);
                // Divisor change mid-frame applies to the next frame only
                send(9'h081, 4, 1'b0, 4);
                repeat (5) @(posedge clk);
                #1;
                divisor = 32'd2;
                send(9'h07E, 2, 1'b1, 4);
                wait_idle(200);
                // Divisor 0 behaves as 1
                divisor = 32'd0;
                send(9'h0C3, 1, 1'b0, 4);
                wait_idle(100);
                done_flags[g] = 1'b1;
            end
        end else if (g == 1) begin : g_stim
            initial begin
                rst = 1'b1; valid = 1'b0; data = '0; divisor = 32'd2;
                apply_reset(3);
                send(9'h007, 2, 1'b0, 4);
                wait_idle(100);
                done_flags[g] = 1'b1;
            end
        end else begin : g_stim
            initial begin
                rst = 1'b1; valid = 1'b0; data = '0; divisor = 32'd2;
                apply_reset(3);
                send(9'h007, 2, 1'b0, 4);
                wait_idle(100);
                // Two stop bits of 3 clocks, second word starts right after
                divisor = 32'd3;
                send(9'h020, 3, 1'b0, 4);
                send(9'h055, 3, 1'b1, 4);
                wait_idle(200);
                done_flags[g] = 1'b1;
            end
        end
    end

    initial begin
        int budget;
        budget = 0;
        while (!(done_flags[0] && done_flags[1] && done_flags[2]) && budget < 30000) begin
            @(posedge clk);
            budget++;
        end
        chk("all_configs_done", 32'(done_flags[0] && done_flags[1] && done_flags[2]), 32'd1);
        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter with a small input FIFO. Supports configurable frame format (data bits, parity, stop bits) and a runtime baud divisor. Sits between core-side producers (console, debug output) and the board TX pin. Accepts bytes through a valid/ready handshake and emits back-to-back frames with no idle gap while data is queued.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame, 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; must be a power of two and at least 2.
DIV_WIDTH, 32, width of the divisor input.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
divisor  in  DIV_WIDTH  clocks per bit; a value of 0 is treated as 1
data  in  DATA_BITS  word to send
valid  in  1  producer offers data
ready  out  1  FIFO not full
uart_tx  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset values: uart_tx=1, ready=1, busy=0, fifo_count=0, state IDLE. Reset clears the FIFO.
- Reset mid-frame aborts the frame. uart_tx is 1 after the reset edge.
- Push: data is written when valid && ready at the clock edge. ready = (fifo_count != FIFO_DEPTH), combinational from the count.
- ready does not depend on a same-cycle pop. A full FIFO rejects a push even if it pops in that cycle.
- Pop: occurs only on the IDLE->START or STOP->START transition.
- Simultaneous push and pop leaves fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If fifo_count != 0 at an edge: pop the head into the shift register, latch max(divisor,1) into div_q, set uart_tx<=0, bit counter=0, go to START.
  - Otherwise uart_tx stays 1.
- Every non-IDLE bit lasts exactly div_q cycles, counted by a cycle counter that resets at each bit boundary.
- divisor changes during a frame take effect at the next frame.
- START -> DATA: drive data bit 0. Data bits are sent LSB first.
- DATA -> DATA: after DATA_BITS-1 further bit periods.
- DATA -> PARITY when PARITY != 0; otherwise DATA -> STOP.
- Parity bit value:
  - even: XOR of the data bits
  - odd: inverted XOR of the data bits
- PARITY -> STOP: uart_tx <= 1.
- STOP lasts STOP_BITS*div_q cycles. At its end:
  - If the FIFO is non-empty: go directly to START (pop, uart_tx<=0). There is no idle cycle between frames.
  - Otherwise go to IDLE.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)*div_q cycles, measured from the uart_tx falling edge to the next possible start.
- Latency: with an empty FIFO, valid accepted at edge N gives the start bit at edge N+1.
- busy = (state != IDLE) || (fifo_count != 0).
- Counter widths: cycle counter DIV_WIDTH bits, compared against div_q-1 with no overflow. Bit counter is $clog2(DATA_BITS+1) bits.

Test Plan:
- divisor=4, 8N1, push 0x55 once -> uart_tx low 4 cycles, then the bits 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles. busy drops exactly 40 cycles after the start edge.
- PARITY=2, DATA_BITS=7, divisor=2, push 0x07 -> data bits 1,1,1,0,0,0,0 then parity bit 1. PARITY=1 with the same data -> parity bit 0.
- FIFO_DEPTH=4, divisor=8, valid held high with 6 words -> 5 words accepted (1 in flight + 4 queued), ready=0 and fifo_count=4 while full. All 5 frames emitted back-to-back with no high gap beyond the stop bits.
- STOP_BITS=2, divisor=3, push 0xA0 -> stop high for 6 cycles. A second queued word's start bit begins on the next edge.
- Reset asserted during data bit 3 -> uart_tx=1, fifo_count=0, ready=1, busy=0 after the edge. A fresh push afterwards produces a correct full frame.
- Change divisor from 4 to 2 mid-frame -> the current frame keeps 4 cycles per bit and the next frame uses 2. divisor=0 -> each bit lasts 1 cycle.
